// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared state, opcode and ALUOp encodings for the MIPS32 control sequencer
package mips_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/mips_ctrl_fsm.sv
// rtl/mips_ctrl_fsm.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the MIPS32 datapath
module mips_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ir_en,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic             reg_wr,
    output logic             pc_src,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_e           state_q;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            case (state_q)
                S_FETCH: state_q <= S_DECODE;
                S_DECODE: begin
                    op_q    <= opcode;
                    state_q <= op_is_legal(opcode) ? S_EXEC : S_FETCH;
                end
                S_EXEC: begin
                    if (op_q == OP_BEQ) begin
                        state_q   <= S_FETCH;
                        retired_q <= retired_q + CNT_W'(1);
                    end else if (op_q == OP_LW || op_q == OP_SW) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (op_q == OP_SW) begin
                            state_q   <= S_FETCH;
                            retired_q <= retired_q + CNT_W'(1);
                        end else begin
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    state_q   <= S_FETCH;
                    retired_q <= retired_q + CNT_W'(1);
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Strobes are gated by rst_n so a mid-instruction reset silences them asynchronously.
    always_comb begin
        pc_en      = 1'b0;
        ir_en      = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        mem_to_reg = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_wr     = 1'b0;
        pc_src     = 1'b0;
        illegal    = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    ir_en = 1'b1;
                    pc_en = 1'b1;
                end
                S_DECODE: illegal = !op_is_legal(opcode);
                S_EXEC: begin
                    if (op_q == OP_BEQ) begin
                        alu_op = ALU_SUB;
                        pc_en  = zero;
                        pc_src = zero;
                    end else if (op_q == OP_LW || op_q == OP_SW) begin
                        alu_op  = ALU_ADD;
                        alu_src = 1'b1;
                    end else begin
                        alu_op = ALU_FUNCT;
                    end
                end
                S_MEM: begin
                    alu_op  = ALU_ADD;
                    alu_src = 1'b1;
                    mem_rd  = (op_q == OP_LW);
                    mem_wr  = (op_q == OP_SW);
                end
                S_WB: begin
                    reg_wr     = 1'b1;
                    mem_to_reg = (op_q == OP_LW);
                end
                default: ;
            endcase
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// tb/tb_mips_ctrl_fsm.sv - self-checking bench for mips_ctrl_fsm against an instruction-level model
module tb_mips_ctrl_fsm;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_en, ir_en, alu_src, mem_to_reg, mem_rd, mem_wr, reg_wr, pc_src, illegal;
    logic [1:0]       alu_op;
    logic [CNT_W-1:0] retired;

    mips_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .ir_en(ir_en), .alu_src(alu_src), .alu_op(alu_op),
        .mem_to_reg(mem_to_reg), .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr),
        .pc_src(pc_src), .illegal(illegal), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             pc_en;
        logic             ir_en;
        logic             alu_src;
        logic [1:0]       alu_op;
        logic             mem_to_reg;
        logic             mem_rd;
        logic             mem_wr;
        logic             reg_wr;
        logic             pc_src;
        logic             illegal;
        logic [CNT_W-1:0] retired;
    } vec_t;

    vec_t             pend[$];
    vec_t             got_v, exp_v;
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] m_retired = '0;

    always @(negedge clk) begin
        if (pend.size() > 0) begin
            exp_v = pend.pop_front();
            got_v = {pc_en, ir_en, alu_src, alu_op, mem_to_reg, mem_rd, mem_wr, reg_wr, pc_src, illegal, retired};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL outputs t=%0t got=%h exp=%h", $time, got_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    // One clock cycle: apply inputs just after the edge, queue what the outputs must be.
    task automatic cycle(input logic [5:0] op, input logic z, input logic mr, input vec_t e);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        pend.push_back(e);
    endtask

    task automatic do_reset(input int ncyc);
        vec_t v;
        v = '0;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        m_retired = '0;
        pend.push_back(v);
        #1;
        chk("reset_strobes", {pc_en, ir_en, mem_rd, mem_wr, reg_wr, illegal}, 0);
        chk("reset_retired", retired, 0);
        for (int i = 1; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            pend.push_back(v);
        end
    endtask

    function automatic logic legal_op(input logic [5:0] op);
        case (op)
            6'h00, 6'h23, 6'h2B, 6'h04: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level model: what each cycle of one instruction must show.
    task automatic run_instr(input logic [5:0] op, input logic z, input int waits, input int abort_mem,
                             output int ncyc, output logic [CNT_W-1:0] fetch_ret);
        vec_t v;
        logic is_lw, is_sw, is_beq;
        is_lw  = (op == 6'h23);
        is_sw  = (op == 6'h2B);
        is_beq = (op == 6'h04);
        ncyc   = 0;

        v = '0; v.ir_en = 1'b1; v.pc_en = 1'b1; v.retired = m_retired;
        cycle(6'($urandom), 1'($urandom), 1'($urandom), v); ncyc++;
        @(negedge clk);
        fetch_ret = retired;

        v = '0; v.illegal = !legal_op(op); v.retired = m_retired;
        cycle(op, 1'($urandom), 1'($urandom), v); ncyc++;
        if (!legal_op(op)) return;

        v = '0; v.retired = m_retired;
        if (is_beq) begin
            v.alu_op = 2'b01; v.pc_en = z; v.pc_src = z;
        end else if (is_lw || is_sw) begin
            v.alu_op = 2'b00; v.alu_src = 1'b1;
        end else begin
            v.alu_op = 2'b10;
        end
        cycle(6'($urandom), z, 1'($urandom), v); ncyc++;
        if (is_beq) begin
            m_retired++;
            return;
        end

        if (is_lw || is_sw) begin
            for (int w = 0; w <= waits; w++) begin
                if (w == abort_mem) return;
                v = '0; v.alu_op = 2'b00; v.alu_src = 1'b1;
                v.mem_rd = is_lw; v.mem_wr = is_sw; v.retired = m_retired;
                cycle(6'($urandom), 1'($urandom), (w == waits), v); ncyc++;
            end
            if (is_sw) begin
                m_retired++;
                return;
            end
        end

        v = '0; v.reg_wr = 1'b1; v.mem_to_reg = is_lw; v.retired = m_retired;
        cycle(6'($urandom), 1'($urandom), 1'($urandom), v); ncyc++;
        m_retired++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int               n;
        logic [CNT_W-1:0] fr;

        do_reset(2);
        run_instr(6'h00, 1'b0, 0, -1, n, fr); chk("rtype_cycles", n, 4); chk("rtype_fetch_ret", fr, 0);
        run_instr(6'h23, 1'b0, 2, -1, n, fr); chk("lw_wait2_cycles", n, 7); chk("lw_fetch_ret", fr, 1);
        run_instr(6'h2B, 1'b0, 0, -1, n, fr); chk("sw_cycles", n, 4); chk("sw_fetch_ret", fr, 2);
        run_instr(6'h04, 1'b1, 0, -1, n, fr); chk("beq_taken_cycles", n, 3); chk("beq1_fetch_ret", fr, 3);
        run_instr(6'h04, 1'b0, 0, -1, n, fr); chk("beq_not_cycles", n, 3); chk("beq0_fetch_ret", fr, 4);
        run_instr(6'h3F, 1'b0, 0, -1, n, fr); chk("illegal_cycles", n, 2); chk("ill_fetch_ret", fr, 5);
        run_instr(6'h00, 1'b0, 0, -1, n, fr); chk("after_ill_fetch_ret", fr, 5);
        run_instr(6'h2B, 1'b0, 1, -1, n, fr); chk("sw_wait1_cycles", n, 5); chk("sw1_fetch_ret", fr, 6);
        run_instr(6'h23, 1'b0, 3, 2, n, fr);  chk("lw_abort_fetch_ret", fr, 7);
        do_reset(2);
        run_instr(6'h00, 1'b0, 0, -1, n, fr); chk("post_reset_fetch_ret", fr, 0);
        run_instr(6'h23, 1'b0, 0, -1, n, fr); chk("lw_nowait_cycles", n, 5); chk("lw0_fetch_ret", fr, 1);
        run_instr(6'h01, 1'b0, 0, -1, n, fr); chk("ill01_fetch_ret", fr, 2);
        run_instr(6'h05, 1'b1, 0, -1, n, fr); chk("ill05_fetch_ret", fr, 2);
        run_instr(6'h04, 1'b1, 0, -1, n, fr); chk("beq_last_fetch_ret", fr, 2);
        run_instr(6'h00, 1'b0, 0, -1, n, fr); chk("final_fetch_ret", fr, 3);
        chk("model_retired", m_retired, 4);

        for (int i = 0; i < 10 && pend.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        chk("queue_drained", pend.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
